// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int REG_AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_muldiv,
    input  logic              ex_branch_taken,
    input  logic              mem_access,
    input  logic              dmem_ready,
    input  logic              imem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              muldiv_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_LAT - 2);

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic dmem_wait;
    logic md_trig;
    logic md_hold;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    assign dmem_wait = mem_access & ~dmem_ready;
    assign md_trig   = (state_q == RUN) & ex_muldiv;
    // Countdown nonzero means EX is still occupied after this cycle.
    assign md_hold   = (state_q == MULDIV) & (cnt_q != '0);
    assign rs1_hit   = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit   = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use  = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

    // State and countdown register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: a data-memory wait freezes the whole sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!dmem_wait) begin
            unique case (state_q)
                RUN: begin
                    if (ex_muldiv) begin
                        state_d = MULDIV;
                        cnt_d   = CNT_INIT;
                    end
                end
                MULDIV: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs: only the highest-priority active hazard drives them
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        muldiv_busy  = (state_q == MULDIV);
        if (dmem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (md_trig | md_hold) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (!imem_ready) begin
            pc_stall     = 1'b1;
            if_id_flush  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counts
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((if_id_flush | id_ex_flush) && flush_cnt_q != 32'hFFFF_FFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Drives stall and flush enables for the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Resolves, in fixed priority order:
  - data-memory wait
  - multi-cycle mul/div occupancy of EX
  - taken-branch redirect
  - load-use hazard
  - instruction-memory wait
- Contains a small FSM and countdown counter for the multi-cycle EX operations.
- All other hazard decisions are Mealy, combinational from the current-cycle inputs.

Parameters:
- MULDIV_LAT, 4, total EX-stage occupancy in cycles of a mul/div instruction; legal range 2..16.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- id_rs1  input  REG_AW  rs1 of the instruction in ID
- id_rs2  input  REG_AW  rs2 of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  REG_AW  destination register of the instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_muldiv  input  1  EX instruction is mul/div
- ex_branch_taken  input  1  EX resolved a taken branch or jump
- mem_access  input  1  MEM stage issuing a data-memory access
- dmem_ready  input  1  data memory completes this cycle
- imem_ready  input  1  instruction fetch data valid this cycle
- pc_stall  output  1  hold PC
- if_id_stall  output  1  hold if_id
- if_id_flush  output  1  load bubble (instruction 0x00000013) into if_id
- id_ex_stall  output  1  hold id_ex
- id_ex_flush  output  1  load bubble into id_ex
- ex_mem_stall  output  1  hold ex_mem
- ex_mem_flush  output  1  load bubble into ex_mem
- mem_wb_flush  output  1  load bubble into mem_wb
- muldiv_busy  output  1  FSM in MULDIV state

Behaviour:
- Reset:
  - FSM state RUN, counter 0.
  - All outputs 0 given idle inputs (imem_ready=1, others 0).
  - Reset asserted mid-MULDIV returns to RUN immediately, counter cleared.
- Stall and flush rules:
  - Stall and flush of the same register are never both 1; stall wins.
  - Only the highest-priority active condition below drives the outputs.
- P1 DMEM wait (mem_access & !dmem_ready):
  - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1.
  - FSM and counter frozen.
  - ex_branch_taken ignored; EX holds it and re-presents it next cycle.
- P2 mul/div sequencing:
  - Trigger: state RUN & ex_muldiv = 1. Drives the MULDIV outputs this cycle; next state MULDIV, counter = MULDIV_LAT-2.
  - MULDIV with counter != 0: pc_stall, if_id_stall, id_ex_stall = 1; ex_mem_flush = 1; counter decrements.
  - MULDIV with counter == 0: release cycle, no P2 outputs; the instruction advances; next state RUN.
  - Totals: EX occupancy = MULDIV_LAT cycles; stall asserted MULDIV_LAT-1 cycles.
  - muldiv_busy = 1 exactly while state is MULDIV.
  - Back-to-back mul/div: the RUN cycle after release re-triggers on the new EX instruction.
- P3 branch (ex_branch_taken):
  - if_id_flush = 1, id_ex_flush = 1; PC not stalled, so the target loads.
  - Overrides load-use and imem wait in the same cycle.
- P4 load-use:
  - Condition: ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - Response: pc_stall, if_id_stall = 1; id_ex_flush = 1.
  - Exactly one bubble per hazard, because the load leaves EX next cycle.
- P5 imem wait (!imem_ready): pc_stall = 1, if_id_flush = 1.
- No condition active: all outputs 0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [31:0]: increments every cycle pc_stall = 1.
  - Adds output perf_flush_cnt [31:0]: increments every cycle id_ex_flush | if_id_flush = 1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_stall=1, if_id_stall=1, id_ex_flush=1 that cycle; all 0 next cycle. Repeat with ex_rd=0 -> no stall.
- Mul/div, MULDIV_LAT=4: ex_muldiv=1 held -> stall outputs 1 for cycles 1-3, 0 in cycle 4; muldiv_busy=1 for cycles 2-4; back in RUN at cycle 5, re-triggering while ex_muldiv stays 1.
- Branch + load-use same cycle: ex_branch_taken=1 with a matching load-use -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- DMEM wait during MULDIV: mem_access=1, dmem_ready=0 for 3 cycles mid-count -> all four stalls plus mem_wb_flush; counter frozen; total mul/div stall extended by exactly 3 cycles.
- imem_ready=0 for 2 cycles -> pc_stall=1 and if_id_flush=1 for exactly 2 cycles.
- Assert rst_n=0 in MULDIV with counter=1 -> muldiv_busy=0 and outputs 0 immediately; release and idle inputs -> outputs stay 0. With HAZARD_PERF_EN, counters read 0.
